// File: rtl/hsv_pkg.sv
// ---------------------------------------------------------------------------
// hsv_pkg -- shared constants and types for the HSV-to-RGB converter.
//   HUE_PER_SECTOR  : hue units spanned by one 60-degree colour sector
//   HUE_MAX_DEFAULT : default hue units per full circle (2 degrees per unit)
//   sector_e        : the six colour sectors, in hue order
// ---------------------------------------------------------------------------
package hsv_pkg;

  localparam int HUE_PER_SECTOR  = 30;
  localparam int HUE_MAX_DEFAULT = 180;

  typedef enum logic [2:0] {
    SEC_RY = 3'd0,  // red -> yellow
    SEC_YG = 3'd1,  // yellow -> green
    SEC_GC = 3'd2,  // green -> cyan
    SEC_CB = 3'd3,  // cyan -> blue
    SEC_BM = 3'd4,  // blue -> magenta
    SEC_MR = 3'd5   // magenta -> red
  } sector_e;

endpackage

// File: rtl/hsv_to_rgb_div30.sv
// ---------------------------------------------------------------------------
// div30 -- exact combinational floor division by the hue-per-sector constant.
// Ports:
//   num_i [width_p-1:0] : unsigned dividend
//   quo_o [width_p-1:0] : floor(num_i / 30)
//   rem_o [4:0]         : num_i mod 30 (always 0..29)
// width_p must be at least 5 so the divisor fits.
// ---------------------------------------------------------------------------
module div30
  import hsv_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic [width_p-1:0] num_i,
  output logic [width_p-1:0] quo_o,
  output logic [4:0]         rem_o
);

  localparam logic [width_p-1:0] Divisor = width_p'(HUE_PER_SECTOR);

  logic [width_p-1:0] rem_full;

  assign quo_o    = num_i / Divisor;
  // quo_o * Divisor never exceeds num_i, so the subtraction cannot wrap.
  assign rem_full = num_i - quo_o * Divisor;
  assign rem_o    = rem_full[4:0];

endmodule

// File: rtl/hsv_to_rgb.sv
// ---------------------------------------------------------------------------
// hsv_to_rgb -- 3-stage elastic pipeline converting (hue, value) at full
// saturation into RGB.
//   S1: hue range fix-up, sector = h/30, f = h mod 30
//   S2: t = floor(v*f/30), q = v - t
//   S3: per-sector channel select into the output registers
// Ports:
//   clk_i, reset_i        : clock, synchronous active-high reset
//   valid_i, ready_o      : upstream handshake
//   h_i, v_i              : hue (0..hue_max_p-1) and value
//   valid_o, ready_i      : downstream handshake
//   red_o, green_o, blue_o: RGB result, held while stalled
// Build option: define HSV_TO_RGB_CLAMP_EN to clamp out-of-range hue to
// hue_max_p-1; otherwise out-of-range hue wraps by subtracting hue_max_p.
// ---------------------------------------------------------------------------
module hsv_to_rgb
  import hsv_pkg::*;
#(
  parameter int width_p   = 8,
  parameter int hue_max_p = HUE_MAX_DEFAULT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] h_i,
  input  logic [width_p-1:0] v_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [width_p-1:0] red_o,
  output logic [width_p-1:0] green_o,
  output logic [width_p-1:0] blue_o,
  input  logic               ready_i
);

  localparam int               ProdW  = width_p + 5;
  localparam logic [width_p-1:0] HueMax = width_p'(hue_max_p);
  localparam logic [width_p-1:0] LastSector = width_p'(5);

  // Stage registers
  logic               valid_s1_q, valid_s2_q, valid_s3_q;
  sector_e            sector_s1_q, sector_s2_q;
  logic [4:0]         f_s1_q;
  logic [width_p-1:0] v_s1_q, v_s2_q, t_s2_q, q_s2_q;
  logic [width_p-1:0] red_q, green_q, blue_q;

  // Next-state values
  sector_e            sector_s1_d;
  logic [4:0]         f_s1_d;
  logic [width_p-1:0] t_s2_d, q_s2_d;
  logic [width_p-1:0] red_d, green_d, blue_d;

  // A stage loads when it is empty or its contents move on this cycle.
  logic adv_s1, adv_s2, adv_s3;
  assign adv_s3 = ~valid_s3_q | ready_i;
  assign adv_s2 = ~valid_s2_q | adv_s3;
  assign adv_s1 = ~valid_s1_q | adv_s2;

  assign ready_o = adv_s1;
  assign valid_o = valid_s3_q;
  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;

  // ---------------- S1: hue fix-up, sector and remainder ----------------
  logic [width_p-1:0] h_eff;
  logic [width_p-1:0] sector_full;

  always_comb begin
    h_eff = h_i;
    if (h_i >= HueMax) begin
`ifdef HSV_TO_RGB_CLAMP_EN
      h_eff = HueMax - 1'b1;
`else
      h_eff = h_i - HueMax;
`endif
    end
  end

  div30 #(.width_p(width_p)) u_div_hue (
    .num_i (h_eff),
    .quo_o (sector_full),
    .rem_o (f_s1_d)
  );

  // Only reachable with a non-default hue_max_p; keeps the enum legal.
  assign sector_s1_d = (sector_full > LastSector) ? SEC_MR : sector_e'(sector_full[2:0]);

  // ---------------- S2: products ----------------
  logic [ProdW-1:0] prod_s2;
  logic [ProdW-1:0] t_full;
  logic [4:0]       prod_rem_unused;

  // v*f <= (2^width_p - 1) * 29 fits in width_p+5 bits.
  assign prod_s2 = ProdW'(v_s1_q) * ProdW'(f_s1_q);

  div30 #(.width_p(ProdW)) u_div_prod (
    .num_i (prod_s2),
    .quo_o (t_full),
    .rem_o (prod_rem_unused)
  );

  // f <= 29 guarantees t < v, so t fits width_p and q never wraps.
  assign t_s2_d = t_full[width_p-1:0];
  assign q_s2_d = v_s1_q - t_s2_d;

  // ---------------- S3: channel select ----------------
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    unique case (sector_s2_q)
      SEC_RY: begin red_d = v_s2_q; green_d = t_s2_q; end
      SEC_YG: begin red_d = q_s2_q; green_d = v_s2_q; end
      SEC_GC: begin green_d = v_s2_q; blue_d = t_s2_q; end
      SEC_CB: begin green_d = q_s2_q; blue_d = v_s2_q; end
      SEC_BM: begin red_d = t_s2_q; blue_d = v_s2_q; end
      SEC_MR: begin red_d = v_s2_q; blue_d = q_s2_q; end
      default: ;
    endcase
  end

  // ---------------- Pipeline registers ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_s1_q  <= 1'b0;
      valid_s2_q  <= 1'b0;
      valid_s3_q  <= 1'b0;
      sector_s1_q <= SEC_RY;
      sector_s2_q <= SEC_RY;
      f_s1_q      <= '0;
      v_s1_q      <= '0;
      v_s2_q      <= '0;
      t_s2_q      <= '0;
      q_s2_q      <= '0;
      red_q       <= '0;
      green_q     <= '0;
      blue_q      <= '0;
    end else begin
      if (adv_s1) begin
        valid_s1_q <= valid_i;
        if (valid_i) begin
          sector_s1_q <= sector_s1_d;
          f_s1_q      <= f_s1_d;
          v_s1_q      <= v_i;
        end
      end
      if (adv_s2) begin
        valid_s2_q <= valid_s1_q;
        if (valid_s1_q) begin
          sector_s2_q <= sector_s1_q;
          v_s2_q      <= v_s1_q;
          t_s2_q      <= t_s2_d;
          q_s2_q      <= q_s2_d;
        end
      end
      if (adv_s3) begin
        valid_s3_q <= valid_s2_q;
        // Output data only changes when a new pixel arrives, so a stalled
        // pixel stays put and an emptied stage keeps its last colour.
        if (valid_s2_q) begin
          red_q   <= red_d;
          green_q <= green_d;
          blue_q  <= blue_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// ---------------------------------------------------------------------------
// tb_hsv_to_rgb -- scoreboard bench for hsv_to_rgb (default parameters).
// Accepted pixels push a reference colour; delivered pixels pop and compare.
// ---------------------------------------------------------------------------
module tb_hsv_to_rgb;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       valid_i = 1'b0;
  logic [7:0] h_i = '0;
  logic [7:0] v_i = '0;
  logic       ready_o;
  logic       valid_o;
  logic [7:0] red_o, green_o, blue_o;
  logic       ready_i = 1'b1;

  hsv_to_rgb #(.width_p(8), .hue_max_p(180)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .h_i     (h_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .red_o   (red_o),
    .green_o (green_o),
    .blue_o  (blue_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int h;
    int v;
    int r;
    int g;
    int b;
    int acc_cyc;
    bit lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  bit   lat_en = 1'b0;
  bit   consec_en = 1'b0;
  bit   have_last = 1'b0;
  int   last_out_cyc = 0;
  bit   stall_prev = 1'b0;
  logic [24:0] held_prev = '0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference conversion, straight from the hue/value definition.
  function automatic exp_t model(input int h, input int v);
    exp_t e;
    int hh, sec, f, t, q;
    hh = h;
    if (hh >= 180) begin
`ifdef HSV_TO_RGB_CLAMP_EN
      hh = 179;
`else
      hh = hh - 180;
`endif
    end
    sec = hh / 30;
    f   = hh % 30;
    t   = (v * f) / 30;
    q   = v - t;
    e.h = h; e.v = v; e.acc_cyc = 0; e.lat = 1'b0;
    case (sec)
      0:       begin e.r = v; e.g = t; e.b = 0; end
      1:       begin e.r = q; e.g = v; e.b = 0; end
      2:       begin e.r = 0; e.g = v; e.b = t; end
      3:       begin e.r = 0; e.g = q; e.b = v; end
      4:       begin e.r = t; e.g = 0; e.b = v; end
      default: begin e.r = v; e.g = 0; e.b = q; end
    endcase
    return e;
  endfunction

  // Monitor: everything sampled mid-cycle, describing the coming edge.
  always @(negedge clk_i) begin
    if (stall_prev && !reset_i)
      check("hold", int'({valid_o, red_o, green_o, blue_o}), int'(held_prev));
    if (valid_o && ready_i && !reset_i) begin
      check("sb_nonempty", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("red", red_o, e.r);
        check("green", green_o, e.g);
        check("blue", blue_o, e.b);
        if (e.lat) check("latency", cyc - e.acc_cyc, 3);
        if (consec_en && have_last) check("consecutive", cyc - last_out_cyc, 1);
        have_last = 1'b1;
        last_out_cyc = cyc;
        $display("pixel h=%0d v=%0d -> rgb=(%0d,%0d,%0d)", e.h, e.v, red_o, green_o, blue_o);
      end
    end
    if (valid_i && ready_o && !reset_i) begin
      exp_t e;
      e = model(int'(h_i), int'(v_i));
      e.acc_cyc = cyc;
      e.lat = lat_en;
      sb.push_back(e);
    end
    stall_prev = valid_o && !ready_i && !reset_i;
    held_prev  = {valid_o, red_o, green_o, blue_o};
    if (reset_i) sb.delete();
  end

  task automatic send(input int h, input int v);
    bit ok;
    ok = 1'b0;
    valid_i = 1'b1;
    h_i = 8'(h);
    v_i = 8'(v);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", int'(ready_o), 1);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (sb.size() == 0) break;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  int dir_h[7] = '{0, 60, 120, 15, 179, 90, 200};
  int dir_v[7] = '{255, 255, 255, 200, 255, 0, 255};
  bit rnd_done;

  initial begin
    // Reset state
    reset_i = 1'b1;
    idle(1);
    @(negedge clk_i);
    check("rst_valid_o", valid_o, 0);
    check("rst_rgb", int'({red_o, green_o, blue_o}), 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("rst_ready_o", ready_o, 1);
    idle(1);

    // Directed colours, one at a time, with latency checked
    lat_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(dir_h[i], dir_v[i]);
      idle(4);
    end
    drain();
    lat_en = 1'b0;

    // Eight back-to-back pixels with the sink always ready
    consec_en = 1'b1;
    have_last = 1'b0;
    for (int i = 0; i < 8; i++) send(i * 22, 255 - i * 17);
    drain();
    consec_en = 1'b0;
    idle(2);

    // Eight back-to-back pixels with a 5-cycle sink stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send(i * 23 + 5, 100 + i * 19);
      end
      begin
        idle(3);
        ready_i = 1'b0;
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        check("ready_o_stall", ready_o, 0);
        @(posedge clk_i);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();
    idle(2);

    // Random hue/value (including out-of-range hue) under random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send($urandom_range(0, 255), $urandom_range(0, 255));
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk_i);
          #1;
          ready_i = 1'($urandom_range(0, 1));
        end
        ready_i = 1'b1;
      end
    join
    drain();
    idle(2);

    // Reset with three pixels stalled in flight
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(30 + i * 40, 180);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check("midrst_valid_o", valid_o, 0);
    check("midrst_ready_o", ready_o, 1);
    ready_i = 1'b1;
    idle(8);
    check("midrst_sb_empty", sb.size(), 0);

    // Pipeline still works after the mid-stream reset
    send(60, 255);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
